baccarat_datapath: RTL and testbench

Card-dealing and scoring datapath for the baccarat game: owns the six card registers, a free-running card dealer and the two hand-score adders. It sits directly beside `statemachine`, consuming its six `load_*` strobes and producing `pscore`, `dscore` and `pcard3`, which feed the state machine's transition logic. It also exposes all card registers to the display stage.

---
 rtl/baccarat_if.sv | 37 +++
 rtl/baccarat_datapath.sv | 106 ++++++++++
 tb/tb_baccarat_datapath.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/baccarat_if.sv
// Signal bundle between the baccarat state machine and the card/score datapath.
// The master drives load strobes and the external card; the slave returns cards and scores.
interface baccarat_if;
    logic       load_pcard1;
    logic       load_pcard2;
    logic       load_pcard3;
    logic       load_dcard1;
    logic       load_dcard2;
    logic       load_dcard3;
    logic       ext_card_en;
    logic [3:0] ext_card;
    logic [3:0] pcard1;
    logic [3:0] pcard2;
    logic [3:0] pcard3;
    logic [3:0] dcard1;
    logic [3:0] dcard2;
    logic [3:0] dcard3;
    logic [3:0] pscore;
    logic [3:0] dscore;
    logic [2:0] cards_dealt;

    modport master (
        output load_pcard1, load_pcard2, load_pcard3,
        output load_dcard1, load_dcard2, load_dcard3,
        output ext_card_en, ext_card,
        input  pcard1, pcard2, pcard3, dcard1, dcard2, dcard3,
        input  pscore, dscore, cards_dealt
    );

    modport slave (
        input  load_pcard1, load_pcard2, load_pcard3,
        input  load_dcard1, load_dcard2, load_dcard3,
        input  ext_card_en, ext_card,
        output pcard1, pcard2, pcard3, dcard1, dcard2, dcard3,
        output pscore, dscore, cards_dealt
    );
endinterface

// File: rtl/baccarat_datapath.sv
// Baccarat card registers, free-running 1..13 dealer counter and mod-10 hand scoring.
module baccarat_datapath #(
    parameter logic [3:0] DEAL_SEED = 4'd1
) (
    input  logic       slow_clock,
    input  logic       resetb,
    baccarat_if.slave  bus
);

    logic [3:0] deal_cnt_r;
    logic [3:0] pcard1_r, pcard2_r, pcard3_r;
    logic [3:0] dcard1_r, dcard2_r, dcard3_r;
    logic [2:0] cards_dealt_r;
    logic [3:0] deal_card_s;
    logic [3:0] deal_cnt_nxt_s;
    logic       any_load_s;
    logic [4:0] psum_s, dsum_s;
    logic [3:0] pscore_s, dscore_s;

    function automatic logic [4:0] card_value(input logic [3:0] code);
        logic [4:0] v;
        case (code)
            4'd1, 4'd2, 4'd3, 4'd4, 4'd5,
            4'd6, 4'd7, 4'd8, 4'd9: v = {1'b0, code};
            default:                v = 5'd0;
        endcase
        return v;
    endfunction

    // Raw sum never exceeds 27, so one conditional subtract of 20 or 10 suffices.
    function automatic logic [3:0] mod10(input logic [4:0] sum);
        logic [4:0] r;
        if (sum >= 5'd20) begin
            r = sum - 5'd20;
        end else if (sum >= 5'd10) begin
            r = sum - 5'd10;
        end else begin
            r = sum;
        end
        return r[3:0];
    endfunction

    // Dealt card selection, counter successor and any-strobe detect.
    always_comb begin
        deal_card_s    = deal_cnt_r;
        deal_cnt_nxt_s = 4'd1;
        any_load_s     = 1'b0;
        if (bus.ext_card_en) begin
            deal_card_s = bus.ext_card;
        end else begin
            deal_card_s = deal_cnt_r;
        end
        // Out-of-range values also fall back to 1 so 0/14/15 can never persist.
        if ((deal_cnt_r >= 4'd13) || (deal_cnt_r == 4'd0)) begin
            deal_cnt_nxt_s = 4'd1;
        end else begin
            deal_cnt_nxt_s = deal_cnt_r + 4'd1;
        end
        any_load_s = bus.load_pcard1 | bus.load_pcard2 | bus.load_pcard3 |
                     bus.load_dcard1 | bus.load_dcard2 | bus.load_dcard3;
    end

    // Dealer counter, card registers and dealt-card counter.
    always_ff @(posedge slow_clock or negedge resetb) begin
        if (!resetb) begin
            deal_cnt_r    <= DEAL_SEED;
            pcard1_r      <= 4'd0;
            pcard2_r      <= 4'd0;
            pcard3_r      <= 4'd0;
            dcard1_r      <= 4'd0;
            dcard2_r      <= 4'd0;
            dcard3_r      <= 4'd0;
            cards_dealt_r <= 3'd0;
        end else begin
            deal_cnt_r <= deal_cnt_nxt_s;
            if (bus.load_pcard1) pcard1_r <= deal_card_s;
            if (bus.load_pcard2) pcard2_r <= deal_card_s;
            if (bus.load_pcard3) pcard3_r <= deal_card_s;
            if (bus.load_dcard1) dcard1_r <= deal_card_s;
            if (bus.load_dcard2) dcard2_r <= deal_card_s;
            if (bus.load_dcard3) dcard3_r <= deal_card_s;
            if (any_load_s && (cards_dealt_r != 3'd6)) begin
                cards_dealt_r <= cards_dealt_r + 3'd1;
            end
        end
    end

    // Hand scores follow the card registers combinationally.
    always_comb begin
        psum_s   = card_value(pcard1_r) + card_value(pcard2_r) + card_value(pcard3_r);
        dsum_s   = card_value(dcard1_r) + card_value(dcard2_r) + card_value(dcard3_r);
        pscore_s = mod10(psum_s);
        dscore_s = mod10(dsum_s);
    end

    assign bus.pcard1      = pcard1_r;
    assign bus.pcard2      = pcard2_r;
    assign bus.pcard3      = pcard3_r;
    assign bus.dcard1      = dcard1_r;
    assign bus.dcard2      = dcard2_r;
    assign bus.dcard3      = dcard3_r;
    assign bus.pscore      = pscore_s;
    assign bus.dscore      = dscore_s;
    assign bus.cards_dealt = cards_dealt_r;

endmodule

// File: tb/tb_baccarat_datapath.sv
// Self-checking bench for baccarat_datapath: directed vector table, corner sequences
// and randomized loads checked against an arithmetic model of the dealing rules.
module tb_baccarat_datapath;

    logic clk;
    logic resetb;

    baccarat_if bus ();
    baccarat_if bus13 ();

    baccarat_datapath #(.DEAL_SEED(4'd1)) dut (
        .slow_clock (clk),
        .resetb     (resetb),
        .bus        (bus)
    );

    baccarat_datapath #(.DEAL_SEED(4'd13)) dut13 (
        .slow_clock (clk),
        .resetb     (resetb),
        .bus        (bus13)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_tests = 0;
    int n_fail  = 0;

    // Model state: six card slots (p1,p2,p3,d1,d2,d3), edges since reset, loads taken.
    int m_card [6];
    int m_edges;
    int m_dealt;
    localparam int SEED = 1;

    typedef struct {
        bit         rst;
        logic [5:0] ld;   // {d3,d2,d1,p3,p2,p1}
        logic       en;
        logic [3:0] ext;
        int         ep;
        int         ed;
        int         ec;
    } vec_t;

    vec_t tbl [15];

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int val(input int c);
        return (c >= 1 && c <= 9) ? c : 0;
    endfunction

    function automatic int m_counter();
        return ((SEED - 1 + m_edges) % 13) + 1;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 6; i++) m_card[i] = 0;
        m_edges = 0;
        m_dealt = 0;
    endtask

    task automatic set_strobes(input logic [5:0] ld, input logic en, input logic [3:0] ext);
        bus.load_pcard1 = ld[0];
        bus.load_pcard2 = ld[1];
        bus.load_pcard3 = ld[2];
        bus.load_dcard1 = ld[3];
        bus.load_dcard2 = ld[4];
        bus.load_dcard3 = ld[5];
        bus.ext_card_en = en;
        bus.ext_card    = ext;
    endtask

    // Apply one clock edge with the given strobes; update the model; sample 1ns later.
    task automatic do_edge(input logic [5:0] ld, input logic en, input logic [3:0] ext);
        int dealt;
        set_strobes(ld, en, ext);
        dealt = en ? int'(ext) : m_counter();
        for (int i = 0; i < 6; i++) if (ld[i]) m_card[i] = dealt;
        if (ld != 6'd0 && m_dealt < 6) m_dealt++;
        m_edges++;
        @(posedge clk);
        #1;
        set_strobes(6'd0, 1'b0, 4'd0);
    endtask

    // Pulse reset between edges (called at posedge+1).
    task automatic do_reset();
        resetb = 1'b0;
        #1;
        resetb = 1'b1;
        model_reset();
    endtask

    task automatic check_model(input string tag);
        int ps, ds;
        ps = (val(m_card[0]) + val(m_card[1]) + val(m_card[2])) % 10;
        ds = (val(m_card[3]) + val(m_card[4]) + val(m_card[5])) % 10;
        chk({tag, ".pcard1"}, int'(bus.pcard1), m_card[0]);
        chk({tag, ".pcard2"}, int'(bus.pcard2), m_card[1]);
        chk({tag, ".pcard3"}, int'(bus.pcard3), m_card[2]);
        chk({tag, ".dcard1"}, int'(bus.dcard1), m_card[3]);
        chk({tag, ".dcard2"}, int'(bus.dcard2), m_card[4]);
        chk({tag, ".dcard3"}, int'(bus.dcard3), m_card[5]);
        chk({tag, ".pscore"}, int'(bus.pscore), ps);
        chk({tag, ".dscore"}, int'(bus.dscore), ds);
        chk({tag, ".cards_dealt"}, int'(bus.cards_dealt), m_dealt);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, ".pcard1"}, int'(bus.pcard1), 0);
        chk({tag, ".pcard2"}, int'(bus.pcard2), 0);
        chk({tag, ".pcard3"}, int'(bus.pcard3), 0);
        chk({tag, ".dcard1"}, int'(bus.dcard1), 0);
        chk({tag, ".dcard2"}, int'(bus.dcard2), 0);
        chk({tag, ".dcard3"}, int'(bus.dcard3), 0);
        chk({tag, ".pscore"}, int'(bus.pscore), 0);
        chk({tag, ".dscore"}, int'(bus.dscore), 0);
        chk({tag, ".cards_dealt"}, int'(bus.cards_dealt), 0);
    endtask

    initial begin
        resetb = 1'b0;
        set_strobes(6'd0, 1'b0, 4'd0);
        bus13.load_pcard1 = 1'b0;
        bus13.load_pcard2 = 1'b0;
        bus13.load_pcard3 = 1'b0;
        bus13.load_dcard1 = 1'b0;
        bus13.load_dcard2 = 1'b0;
        bus13.load_dcard3 = 1'b0;
        bus13.ext_card_en = 1'b0;
        bus13.ext_card    = 4'd0;
        model_reset();

        // Directed vectors: deal from counter, mod-10/face cards, saturation,
        // illegal code, simultaneous strobes, hold with no strobe.
        tbl[0]  = '{1'b1, 6'b000001, 1'b0, 4'd0,  1, 0, 1};
        tbl[1]  = '{1'b0, 6'b001000, 1'b0, 4'd0,  1, 2, 2};
        tbl[2]  = '{1'b0, 6'b000010, 1'b0, 4'd0,  4, 2, 3};
        tbl[3]  = '{1'b0, 6'b010000, 1'b0, 4'd0,  4, 6, 4};
        tbl[4]  = '{1'b1, 6'b000001, 1'b1, 4'd9,  9, 0, 1};
        tbl[5]  = '{1'b0, 6'b000010, 1'b1, 4'd9,  8, 0, 2};
        tbl[6]  = '{1'b0, 6'b000100, 1'b1, 4'd12, 8, 0, 3};
        tbl[7]  = '{1'b0, 6'b001000, 1'b1, 4'd7,  8, 7, 4};
        tbl[8]  = '{1'b0, 6'b010000, 1'b1, 4'd13, 8, 7, 5};
        tbl[9]  = '{1'b0, 6'b100000, 1'b1, 4'd10, 8, 7, 6};
        tbl[10] = '{1'b0, 6'b000100, 1'b1, 4'd9,  7, 7, 6};
        tbl[11] = '{1'b0, 6'b000001, 1'b1, 4'd15, 8, 7, 6};
        tbl[12] = '{1'b1, 6'b100100, 1'b1, 4'd6,  6, 6, 1};
        tbl[13] = '{1'b1, 6'b000001, 1'b1, 4'd15, 0, 0, 1};
        tbl[14] = '{1'b0, 6'b000000, 1'b0, 4'd0,  0, 0, 1};

        #12;
        check_all_zero("reset");
        resetb = 1'b1;

        for (int i = 0; i < 15; i++) begin
            if (tbl[i].rst) do_reset();
            do_edge(tbl[i].ld, tbl[i].en, tbl[i].ext);
            chk($sformatf("vec%0d.pscore", i), int'(bus.pscore), tbl[i].ep);
            chk($sformatf("vec%0d.dscore", i), int'(bus.dscore), tbl[i].ed);
            chk($sformatf("vec%0d.cards_dealt", i), int'(bus.cards_dealt), tbl[i].ec);
            check_model($sformatf("vec%0d", i));
        end
        chk("ext15.pcard1", int'(bus.pcard1), 15);

        // Counter wrap: 13 idle edges, then load gives 1 again.
        do_reset();
        for (int i = 0; i < 13; i++) do_edge(6'd0, 1'b0, 4'd0);
        do_edge(6'b000001, 1'b0, 4'd0);
        chk("wrap.pcard1", int'(bus.pcard1), 1);
        check_model("wrap");

        // Seed 13 instance: first-edge load gives 13, next gives 1.
        do_reset();
        bus13.load_pcard1 = 1'b1;
        do_edge(6'd0, 1'b0, 4'd0);
        bus13.load_pcard1 = 1'b0;
        bus13.load_pcard2 = 1'b1;
        do_edge(6'd0, 1'b0, 4'd0);
        bus13.load_pcard2 = 1'b0;
        chk("seed13.pcard1", int'(bus13.pcard1), 13);
        chk("seed13.pcard2", int'(bus13.pcard2), 1);
        chk("seed13.pscore", int'(bus13.pscore), 1);
        chk("seed13.cards_dealt", int'(bus13.cards_dealt), 2);

        // Reset mid-hand: clears without a clock edge, counter back to seed.
        do_reset();
        do_edge(6'b000001, 1'b0, 4'd0);
        do_edge(6'b001000, 1'b0, 4'd0);
        do_edge(6'b000010, 1'b0, 4'd0);
        check_model("prereset");
        resetb = 1'b0;
        #1;
        check_all_zero("midreset");
        chk("midreset.seed13_pcard1", int'(bus13.pcard1), 0);
        resetb = 1'b1;
        model_reset();
        do_edge(6'b000001, 1'b0, 4'd0);
        chk("postreset.pcard1", int'(bus.pcard1), 1);
        check_model("postreset");

        // Randomized strobes, external cards and occasional resets.
        for (int n = 0; n < 400; n++) begin
            logic [5:0] ld;
            if ($urandom_range(0, 39) == 0) do_reset();
            for (int b = 0; b < 6; b++) ld[b] = ($urandom_range(0, 3) == 0);
            do_edge(ld, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)));
            check_model($sformatf("rand%0d", n));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
